// File: rtl/xfft_ofdm_framer.sv
`default_nettype none
// ============================================================================
// Module   : xfft_ofdm_framer
// Purpose  : Front-end for the OFDM receive FFT core. Validates a runtime FFT
//            configuration, packs it onto an AXIS config channel, strips the
//            cyclic prefix from the raw sample stream and forwards exactly
//            2^nfft samples per symbol with tlast on the final one.
//            Configuration changes are applied only at symbol boundaries.
// Ports    : aclk / aresetn         clock, asynchronous active-low reset
//            i_nfft .. i_cfg_valid  runtime configuration request
//            o_cfg_ready            pending slot is empty
//            o_cfg_error            one-cycle pulse for a rejected config
//            s_axis_*               raw sample stream in
//            m_axis_data_*          framed sample stream to the FFT
//            m_axis_cfg_*           packed configuration to the FFT
//            o_frame_count          completed symbols (wraps)
//            o_active               a valid configuration is active
// Revision : 1.0 - initial release
// ============================================================================
module xfft_ofdm_framer #(
   parameter int DATA_W      = 32,
   parameter int NFFT_MIN    = 3,
   parameter int NFFT_MAX    = 12,
   parameter int CP_W        = 10,
   parameter int SCALE_W     = 8,
   parameter int CFG_TDATA_W = 40,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [4:0]             i_nfft,
   input  logic [CP_W-1:0]        i_cp_len,
   input  logic                   i_direction,
   input  logic [SCALE_W-1:0]     i_scale,
   input  logic                   i_cfg_valid,
   output logic                   o_cfg_ready,
   output logic                   o_cfg_error,
   input  logic [DATA_W-1:0]      s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [DATA_W-1:0]      m_axis_data_tdata,
   output logic                   m_axis_data_tvalid,
   input  logic                   m_axis_data_tready,
   output logic                   m_axis_data_tlast,
   output logic [CFG_TDATA_W-1:0] m_axis_cfg_tdata,
   output logic                   m_axis_cfg_tvalid,
   input  logic                   m_axis_cfg_tready,
   output logic [FRAME_CNT_W-1:0] o_frame_count,
   output logic                   o_active
);

   // Sample counter is one bit wider than NFFT_MAX so 2^NFFT_MAX-1 fits with margin.
   localparam int c_CNT_W     = NFFT_MAX + 1;
   // Direction bit sits on the first byte boundary after the cp_len field.
   localparam int c_FWD_OFF   = 8 * ((8 + CP_W + 7) / 8);
   localparam int c_SCALE_OFF = c_FWD_OFF + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CFG_SEND = 2'd1,
      ST_CP_DROP  = 2'd2,
      ST_PAYLOAD  = 2'd3
   } state_t;

   state_t                 r_state;

   logic                   r_pend_valid;
   logic [4:0]             r_pend_nfft;
   logic [CP_W-1:0]        r_pend_cp;
   logic                   r_pend_dir;
   logic [SCALE_W-1:0]     r_pend_scale;

   logic                   r_act_valid;
   logic [4:0]             r_act_nfft;
   logic [CP_W-1:0]        r_act_cp;
   logic                   r_act_dir;
   logic [SCALE_W-1:0]     r_act_scale;

   logic [c_CNT_W-1:0]     r_cnt;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;
   logic                   r_cfg_tvalid;
   logic [CFG_TDATA_W-1:0] r_cfg_tdata;
   logic                   r_cfg_error;

   logic                   w_cfg_hs;
   logic                   w_cfg_legal;
   logic                   w_cfg_same;
   logic                   w_in_hs;
   logic                   w_cp_done;
   logic                   w_sym_done;
   logic [c_CNT_W-1:0]     w_sym_last_idx;
   logic [CFG_TDATA_W-1:0] w_pend_pack;
   state_t                 w_resume;

   // ---------------------------------------------------------------------
   // Config validation
   // ---------------------------------------------------------------------
   assign w_cfg_hs    = i_cfg_valid & o_cfg_ready;
   assign w_cfg_legal = (int'(i_nfft) >= NFFT_MIN) && (int'(i_nfft) <= NFFT_MAX) &&
                        (32'(i_cp_len) < (32'd1 << i_nfft));
   // A request matching what is already running needs no new packet.
   assign w_cfg_same  = r_act_valid && (i_nfft == r_act_nfft) && (i_cp_len == r_act_cp) &&
                        (i_direction == r_act_dir) && (i_scale == r_act_scale);

   // ---------------------------------------------------------------------
   // Config packing (unused bits, including [7:5], stay zero)
   // ---------------------------------------------------------------------
   always_comb begin
      w_pend_pack                          = '0;
      w_pend_pack[4:0]                     = r_pend_nfft;
      w_pend_pack[8 +: CP_W]               = r_pend_cp;
      w_pend_pack[c_FWD_OFF]               = r_pend_dir;
      w_pend_pack[c_SCALE_OFF +: SCALE_W]  = r_pend_scale;
   end

   // ---------------------------------------------------------------------
   // Symbol framing helpers, always derived from the active config so a
   // mid-symbol request cannot change the symbol in flight.
   // ---------------------------------------------------------------------
   assign w_in_hs        = s_axis_tvalid & s_axis_tready;
   assign w_sym_last_idx = c_CNT_W'((32'd1 << r_act_nfft) - 32'd1);
   assign w_cp_done      = ((32'(r_cnt) + 32'd1) == 32'(r_act_cp));
   assign w_sym_done     = (r_cnt == w_sym_last_idx);
   assign w_resume       = (r_act_cp == '0) ? ST_PAYLOAD : ST_CP_DROP;

   // ---------------------------------------------------------------------
   // Data path: zero-latency pass-through during payload
   // ---------------------------------------------------------------------
   assign s_axis_tready      = (r_state == ST_CP_DROP) |
                               ((r_state == ST_PAYLOAD) & m_axis_data_tready);
   assign m_axis_data_tvalid = (r_state == ST_PAYLOAD) & s_axis_tvalid;
   assign m_axis_data_tdata  = (r_state == ST_PAYLOAD) ? s_axis_tdata : '0;
   assign m_axis_data_tlast  = (r_state == ST_PAYLOAD) & w_sym_done;

   assign o_cfg_ready        = ~r_pend_valid;
   assign o_cfg_error        = r_cfg_error;
   assign m_axis_cfg_tvalid  = r_cfg_tvalid;
   assign m_axis_cfg_tdata   = r_cfg_tdata;
   assign o_frame_count      = r_frame_cnt;
   assign o_active           = r_act_valid;

   // ---------------------------------------------------------------------
   // Control FSM, config slots and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= ST_IDLE;
         r_pend_valid <= 1'b0;
         r_pend_nfft  <= '0;
         r_pend_cp    <= '0;
         r_pend_dir   <= 1'b0;
         r_pend_scale <= '0;
         r_act_valid  <= 1'b0;
         r_act_nfft   <= '0;
         r_act_cp     <= '0;
         r_act_dir    <= 1'b0;
         r_act_scale  <= '0;
         r_cnt        <= '0;
         r_frame_cnt  <= '0;
         r_cfg_tvalid <= 1'b0;
         r_cfg_tdata  <= '0;
         r_cfg_error  <= 1'b0;
      end else begin
         r_cfg_error <= 1'b0;

         // Intake only happens while the slot is empty, so it never races
         // with the slot being freed in ST_CFG_SEND.
         if (w_cfg_hs) begin
            if (!w_cfg_legal) begin
               r_cfg_error <= 1'b1;
            end else if (!w_cfg_same) begin
               r_pend_valid <= 1'b1;
               r_pend_nfft  <= i_nfft;
               r_pend_cp    <= i_cp_len;
               r_pend_dir   <= i_direction;
               r_pend_scale <= i_scale;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (r_pend_valid) begin
                  r_cfg_tdata  <= w_pend_pack;
                  r_cfg_tvalid <= 1'b1;
                  r_state      <= ST_CFG_SEND;
               end
            end

            ST_CFG_SEND: begin
               if (m_axis_cfg_tready) begin
                  r_cfg_tvalid <= 1'b0;
                  r_cfg_tdata  <= '0;
                  r_act_valid  <= 1'b1;
                  r_act_nfft   <= r_pend_nfft;
                  r_act_cp     <= r_pend_cp;
                  r_act_dir    <= r_pend_dir;
                  r_act_scale  <= r_pend_scale;
                  r_pend_valid <= 1'b0;
                  r_cnt        <= '0;
                  r_state      <= (r_pend_cp == '0) ? ST_PAYLOAD : ST_CP_DROP;
               end
            end

            ST_CP_DROP: begin
               if (s_axis_tvalid) begin
                  if (w_cp_done) begin
                     r_cnt   <= '0;
                     r_state <= ST_PAYLOAD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            ST_PAYLOAD: begin
               if (w_in_hs) begin
                  if (w_sym_done) begin
                     r_cnt       <= '0;
                     r_frame_cnt <= r_frame_cnt + 1'b1;
                     if (r_pend_valid) begin
                        r_cfg_tdata  <= w_pend_pack;
                        r_cfg_tvalid <= 1'b1;
                        r_state      <= ST_CFG_SEND;
                     end else begin
                        r_state <= w_resume;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xfft_ofdm_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xfft_ofdm_framer
// Purpose  : Self-checking bench for xfft_ofdm_framer. Random stream
//            backpressure and config traffic are compared against a
//            transaction-level reference of the framing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xfft_ofdm_framer;
   localparam int DATA_W      = 32;
   localparam int NFFT_MIN    = 3;
   localparam int NFFT_MAX    = 12;
   localparam int CP_W        = 10;
   localparam int SCALE_W     = 8;
   localparam int CFG_TDATA_W = 40;
   localparam int FRAME_CNT_W = 16;

   logic                   aclk = 1'b0;
   logic                   aresetn = 1'b0;
   logic [4:0]             i_nfft = '0;
   logic [CP_W-1:0]        i_cp_len = '0;
   logic                   i_direction = 1'b0;
   logic [SCALE_W-1:0]     i_scale = '0;
   logic                   i_cfg_valid = 1'b0;
   logic                   o_cfg_ready;
   logic                   o_cfg_error;
   logic [DATA_W-1:0]      s_axis_tdata = '0;
   logic                   s_axis_tvalid = 1'b0;
   logic                   s_axis_tready;
   logic [DATA_W-1:0]      m_axis_data_tdata;
   logic                   m_axis_data_tvalid;
   logic                   m_axis_data_tready = 1'b0;
   logic                   m_axis_data_tlast;
   logic [CFG_TDATA_W-1:0] m_axis_cfg_tdata;
   logic                   m_axis_cfg_tvalid;
   logic                   m_axis_cfg_tready = 1'b0;
   logic [FRAME_CNT_W-1:0] o_frame_count;
   logic                   o_active;

   always #5 aclk = ~aclk;

   xfft_ofdm_framer #(
      .DATA_W(DATA_W), .NFFT_MIN(NFFT_MIN), .NFFT_MAX(NFFT_MAX), .CP_W(CP_W),
      .SCALE_W(SCALE_W), .CFG_TDATA_W(CFG_TDATA_W), .FRAME_CNT_W(FRAME_CNT_W)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_nfft(i_nfft), .i_cp_len(i_cp_len), .i_direction(i_direction), .i_scale(i_scale),
      .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .o_cfg_error(o_cfg_error),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
      .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
      .m_axis_cfg_tdata(m_axis_cfg_tdata), .m_axis_cfg_tvalid(m_axis_cfg_tvalid),
      .m_axis_cfg_tready(m_axis_cfg_tready), .o_frame_count(o_frame_count), .o_active(o_active)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model state ----------------
   bit          m_has_act = 0;
   int          m_nfft, m_cp, m_dir, m_scale;
   bit          m_pend_v = 0;
   int          p_nfft, p_cp, p_dir, p_scale;
   int          m_pos = 0;
   int          m_frames = 0;
   bit          exp_err = 0;
   int          err_pulses = 0;
   int          cfg_pkts = 0;
   longint      cfg_q[$];

   // ---------------- stimulus state ----------------
   logic [31:0] next_sample = 0;
   bit          in_hold = 0;
   int          in_pct = 70;
   int          out_pct = 70;
   bit          cfg_rdy_en = 1;
   bit          cfg_req = 0;
   int          req_nfft, req_cp, req_dir, req_scale;
   bit          prev_stall = 0;
   logic [CFG_TDATA_W-1:0] prev_cfg = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Config word from the field layout: nfft at bit 0, cp_len at bit 8,
   // direction on the next byte boundary after cp_len, scale right above it.
   function automatic longint pack(input int nfft, input int cp, input int dir, input int scale);
      longint fwd_off;
      fwd_off = 8 * ((8 + CP_W + 7) / 8);
      return longint'(nfft) + longint'(cp) * 256 +
             longint'(dir) * (64'd1 << fwd_off) + longint'(scale) * (64'd1 << (fwd_off + 1));
   endfunction

   function automatic bit legal(input int nfft, input int cp);
      return (nfft >= NFFT_MIN) && (nfft <= NFFT_MAX) && (cp < (1 << nfft));
   endfunction

   task automatic activate();
      m_nfft = p_nfft; m_cp = p_cp; m_dir = p_dir; m_scale = p_scale;
      m_has_act = 1;
      m_pend_v  = 0;
      cfg_q.push_back(pack(m_nfft, m_cp, m_dir, m_scale));
   endtask

   // Called once per cycle after inputs settle; observes what the coming
   // clock edge will transfer and advances the reference accordingly.
   task automatic monitor();
      bit in_hs, out_hs, fwd, last;
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_data_tvalid && m_axis_data_tready;

      if (exp_err || o_cfg_error) chk("cfg_error", o_cfg_error, exp_err);
      if (o_cfg_error) err_pulses++;
      exp_err = 0;

      if (prev_stall) begin
         chk("cfg_hold_valid", m_axis_cfg_tvalid, 1);
         chk("cfg_hold_data", m_axis_cfg_tdata, prev_cfg);
      end
      if (m_axis_cfg_tvalid) chk("tready_during_cfg", s_axis_tready, 0);
      prev_stall = m_axis_cfg_tvalid && !m_axis_cfg_tready;
      prev_cfg   = m_axis_cfg_tdata;

      if (m_axis_cfg_tvalid && m_axis_cfg_tready) begin
         cfg_pkts++;
         if (cfg_q.size() == 0) chk("cfg_unexpected", 1, 0);
         else chk("cfg_tdata", m_axis_cfg_tdata, cfg_q.pop_front());
      end

      if (in_hs) begin
         in_hold = 0;
         if (!m_has_act) begin
            chk("accept_without_cfg", 1, 0);
         end else begin
            fwd  = (m_pos >= m_cp);
            last = (m_pos == m_cp + (1 << m_nfft) - 1);
            if (fwd) begin
               chk("out_hs", out_hs, 1);
               chk("out_data", m_axis_data_tdata, next_sample);
               chk("out_last", m_axis_data_tlast, last);
            end else begin
               chk("drop_no_valid", m_axis_data_tvalid, 0);
            end
            m_pos++;
            if (last) begin
               m_pos = 0;
               m_frames++;
               if (m_pend_v) activate();
            end
         end
         next_sample++;
      end else if (out_hs) begin
         chk("spurious_out", 1, 0);
      end

      if (i_cfg_valid && o_cfg_ready) begin
         cfg_req = 0;
         if (!legal(req_nfft, req_cp)) begin
            exp_err = 1;
         end else if (!(m_has_act && req_nfft == m_nfft && req_cp == m_cp &&
                        req_dir == m_dir && req_scale == m_scale)) begin
            if (m_pend_v) chk("intake_while_full", 1, 0);
            p_nfft = req_nfft; p_cp = req_cp; p_dir = req_dir; p_scale = req_scale;
            m_pend_v = 1;
            if (!m_has_act) activate();
         end
      end
   endtask

   task automatic step();
      @(negedge aclk);
      if (!in_hold) begin
         s_axis_tvalid = ($urandom_range(0, 99) < in_pct);
         in_hold = s_axis_tvalid;
      end
      s_axis_tdata       = next_sample;
      m_axis_data_tready = ($urandom_range(0, 99) < out_pct);
      m_axis_cfg_tready  = cfg_rdy_en ? ($urandom_range(0, 99) < 80) : 1'b0;
      i_cfg_valid        = cfg_req;
      i_nfft             = 5'(req_nfft);
      i_cp_len           = CP_W'(req_cp);
      i_direction        = req_dir[0];
      i_scale            = SCALE_W'(req_scale);
      #1;
      monitor();
   endtask

   task automatic send_cfg(input int n, input int cp, input int d, input int s);
      int k;
      k = 0;
      req_nfft = n; req_cp = cp; req_dir = d; req_scale = s;
      cfg_req = 1;
      while (cfg_req && k < 200) begin step(); k++; end
      if (cfg_req) begin chk("timeout_cfg", 0, 1); cfg_req = 0; end
   endtask

   task automatic run_frames(input int target, input int budget);
      int k;
      k = 0;
      while (m_frames < target && k < budget) begin step(); k++; end
      if (m_frames < target) chk("timeout_frames", m_frames, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cfg_ready"}, o_cfg_ready, 1);
      chk({tag, "_cfg_error"}, o_cfg_error, 0);
      chk({tag, "_s_tready"}, s_axis_tready, 0);
      chk({tag, "_m_tvalid"}, m_axis_data_tvalid, 0);
      chk({tag, "_m_tdata"}, m_axis_data_tdata, 0);
      chk({tag, "_m_tlast"}, m_axis_data_tlast, 0);
      chk({tag, "_cfg_tvalid"}, m_axis_cfg_tvalid, 0);
      chk({tag, "_cfg_tdata"}, m_axis_cfg_tdata, 0);
      chk({tag, "_frames"}, o_frame_count, 0);
      chk({tag, "_active"}, o_active, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, r;
      // ---- reset ----
      s_axis_tvalid = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      check_reset_outputs("rst");
      @(negedge aclk);
      aresetn = 1'b1;
      s_axis_tvalid = 1'b0;

      // ---- illegal configs: nfft too small, cp not shorter than symbol ----
      send_cfg(2, 0, 1, 8'h55);
      send_cfg(6, 64, 1, 8'h55);
      repeat (6) step();
      chk("illegal_err_pulses", err_pulses, 2);
      chk("illegal_active", o_active, 0);
      chk("illegal_no_pkt", cfg_pkts, 0);

      // ---- first config with the config channel stalled ----
      cfg_rdy_en = 0;
      send_cfg(6, 16, 1, 8'hAA);
      repeat (10) step();
      chk("stall_cfg_tvalid", m_axis_cfg_tvalid, 1);
      chk("stall_cfg_tdata", m_axis_cfg_tdata, pack(6, 16, 1, 8'hAA));
      chk("stall_no_input", next_sample, 0);
      cfg_rdy_en = 1;
      run_frames(1, 2000);
      chk("sym1_inputs", next_sample, 80);
      step();
      chk("sym1_frames", o_frame_count, 1);
      chk("sym1_active", o_active, 1);

      // ---- mid-symbol change to nfft=4, cp=0 ----
      k = 0;
      while (m_pos < 30 && k < 1000) begin step(); k++; end
      send_cfg(4, 0, 1, 8'hAA);
      run_frames(5, 3000);
      chk("switch_inputs", next_sample, 80 + 80 + 16 * 3);
      chk("switch_pkts", cfg_pkts, 2);

      // ---- identical config is dropped ----
      send_cfg(4, 0, 1, 8'hAA);
      run_frames(8, 3000);
      chk("same_inputs", next_sample, 80 + 80 + 16 * 6);
      chk("same_pkts", cfg_pkts, 2);
      step();
      chk("same_frames", o_frame_count, 8);

      // ---- random traffic up to 1000 symbols ----
      k = 0;
      while (m_frames < 1000 && k < 60000) begin
         if (!cfg_req && $urandom_range(0, 99) < 3) begin
            r = $urandom_range(0, 99);
            req_dir   = $urandom_range(0, 1);
            req_scale = $urandom_range(0, 255);
            if (r < 15) begin
               req_nfft = $urandom_range(0, 2); req_cp = 0;
            end else if (r < 25) begin
               req_nfft = 3; req_cp = $urandom_range(8, 20);
            end else if (r < 40 && m_has_act) begin
               req_nfft = m_nfft; req_cp = m_cp; req_dir = m_dir; req_scale = m_scale;
            end else begin
               req_nfft = $urandom_range(3, 4); req_cp = $urandom_range(0, 7);
            end
            cfg_req = 1;
         end
         in_pct  = (k % 4000 < 2000) ? 70 : 95;
         out_pct = (k % 3000 < 1500) ? 60 : 90;
         step();
         k++;
      end
      if (m_frames < 1000) chk("timeout_random", m_frames, 1000);
      step();
      chk("random_frames", o_frame_count, m_frames % (1 << FRAME_CNT_W));
      chk("random_cfg_drained", cfg_q.size() <= 1, 1);

      // ---- asynchronous reset in the middle of a symbol ----
      cfg_req = 0;
      k = 0;
      while (!(m_has_act && m_pos >= 3) && k < 2000) begin step(); k++; end
      @(posedge aclk);
      #3;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      m_has_act = 0; m_pend_v = 0; m_pos = 0; m_frames = 0;
      cfg_q.delete();
      exp_err = 0; in_hold = 0; prev_stall = 0;
      in_pct = 100;
      repeat (6) step();
      chk("post_rst_active", o_active, 0);
      chk("post_rst_frames", o_frame_count, 0);
      chk("post_rst_s_tready", s_axis_tready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
